// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B one bit per clock, LSB first,
// and publishes the difference plus borrow/zero/negative/overflow flags
// together with a one-cycle Done pulse.
module serial_subtractor #(
   parameter int unsigned WIDTH = 24
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Diff,
   output logic             BOUT,
   output logic             Zero,
   output logic             Negative,
   output logic             Overflow
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic             w_accept;
   logic             w_last;
   logic             w_d;
   logic             w_bw_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_a_msb;
   logic             r_b_msb;
   logic             r_bw;
   logic [CW-1:0]    r_cnt;

   // State register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic and one-bit full-subtractor cell
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_last       = (r_cnt == CW'(WIDTH - 1));
      w_d          = r_a[0] ^ r_b[0] ^ r_bw;
      w_bw_next    = (~r_a[0] & r_b[0]) | (~r_a[0] & r_bw) | (r_b[0] & r_bw);
      case (r_state)
         S_IDLE: begin
            if (Start) begin
               w_accept     = 1'b1;
               w_next_state = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_last) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            if (Start) begin
               w_accept     = 1'b1;
               w_next_state = S_SHIFT;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Operand capture, serial shifting, and result/flag publication
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_bw     <= 1'b0;
         r_cnt    <= '0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         Diff     <= '0;
         BOUT     <= 1'b0;
         Zero     <= 1'b0;
         Negative <= 1'b0;
         Overflow <= 1'b0;
      end else begin
         // Status lags the state by one edge so Busy/Done never overlap
         Busy <= (r_state == S_SHIFT);
         Done <= (r_state == S_DONE);

         if (w_accept) begin
            r_a     <= A;
            r_b     <= B;
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
            r_res   <= '0;
            r_bw    <= 1'b0;
            r_cnt   <= '0;
         end else if (r_state == S_SHIFT) begin
            r_a   <= {1'b0, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_res <= {w_d, r_res[WIDTH-1:1]};
            r_bw  <= w_bw_next;
            if (!w_last) begin
               r_cnt <= r_cnt + CW'(1);
            end
         end

         // Outputs only change here, so partial results are never visible
         if (r_state == S_DONE) begin
            Diff     <= r_res;
            BOUT     <= r_bw;
            Zero     <= (r_res == '0);
            Negative <= r_res[WIDTH-1];
            Overflow <= (r_a_msb != r_b_msb) & (r_res[WIDTH-1] != r_a_msb);
         end
      end
   end

endmodule
